axi4lite_cmd_master: RTL

- Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream into AXI4-Lite write or read transactions.
- Sits directly upstream of the team's generated AXI4-Lite register slaves and drives their AW/W/B and AR/R channels.
- Used by sequencers and init engines that need register access without an AXI interconnect.

---
 rtl/axi4lite_cmd_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: each accepted command becomes one AXI4-Lite write or
// read, and its outcome is returned on the response channel before the next command is taken.
module axi4lite_cmd_master #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_we_q, rsp_we_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  aw_done, w_done;

  // A channel counts as done once its valid has dropped or its handshake happens this cycle.
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q || wready;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          awaddr_d = cmd_addr;
          araddr_d = cmd_addr;
          wdata_d  = cmd_wdata;
          wstrb_d  = cmd_wstrb;
          if (cmd_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR: begin
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if (aw_done && w_done) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          rsp_err_d   = (bresp != 2'b00);
          rsp_we_d    = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rsp_rdata_d = rdata;
          rsp_err_d   = (rresp != 2'b00);
          rsp_we_d    = 1'b0;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign bready    = (state_q == WR_RESP);
  assign rready    = (state_q == RD_DATA);
  assign rsp_valid = (state_q == RSP);
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign arvalid   = arvalid_q;
  assign awaddr    = awaddr_q;
  assign araddr    = araddr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_err   = rsp_err_q;

endmodule
